// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - op encodings accepted on mult_div_unit.op
//   - FSM state encoding
//   - default operand width and the LO value written on divide-by-zero
package mdu_pkg;

    localparam int XLEN_DEF = 32;

    // LO value on divide-by-zero: all ones, truncated to XLEN by the user.
    localparam logic [63:0] DIV0_LO = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'd0,
        MDU_MULT  = 2'd1,
        MDU_DIVU  = 2'd2,
        MDU_DIV   = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational sign correction applied in the FIX cycle.
// Ports:
//   prod_i / neg_prod_i -> prod_o : 2*XLEN product, two's-complement negated when requested
//   quo_i  / neg_quo_i  -> quo_o  : quotient, negated when requested
//   rem_i  / neg_rem_i  -> rem_o  : remainder, negated when requested
module mdu_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] prod_i,
    input  logic              neg_prod_i,
    input  logic [XLEN-1:0]   quo_i,
    input  logic              neg_quo_i,
    input  logic [XLEN-1:0]   rem_i,
    input  logic              neg_rem_i,
    output logic [2*XLEN-1:0] prod_o,
    output logic [XLEN-1:0]   quo_o,
    output logic [XLEN-1:0]   rem_o
);

    // Conditional two's-complement negation of product, quotient and remainder.
    always_comb begin
        prod_o = prod_i;
        quo_o  = quo_i;
        rem_o  = rem_i;
        if (neg_prod_i) begin
            prod_o = ~prod_i + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            prod_o = prod_i;
        end
        if (neg_quo_i) begin
            quo_o = ~quo_i + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            quo_o = quo_i;
        end
        if (neg_rem_i) begin
            rem_o = ~rem_i + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            rem_o = rem_i;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start, op           : launch request (sampled only in IDLE) and operation select
//   src_a, src_b        : rs (multiplicand/dividend), rt (multiplier/divisor)
//   hi_we, lo_we, wdata : MTHI/MTLO writes, honoured only when idle and no start is taken
//   busy                : operation in progress (state != IDLE)
//   done, div_zero      : one-cycle completion pulse and zero-divisor flag
//   hi, lo              : architectural HI/LO registers
// Build option: define MDU_EARLY_TERM_EN to stop multiplies once the remaining
// multiplier bits are all zero (results unchanged, divide unaffected).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mdu_state_e          state_q, state_d;
    mdu_op_e             op_q, op_d;
    // Multiply: acc = running product, sh = multiplicand shifted left, q = multiplier shifted right.
    // Divide:   acc[XLEN-1:0] = partial remainder, sh[XLEN-1:0] = divisor, q = dividend -> quotient.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   sh_q, sh_d;
    logic [XLEN-1:0]     q_q, q_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic                dz_q, dz_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d, dzo_q, dzo_d;

    logic                a_neg_s, b_neg_s, is_div_s, run_div_s, step_last_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s;
    logic [XLEN:0]       rem_sh_s, diff_s;
    logic [2*XLEN-1:0]   prod_fix_s;
    logic [XLEN-1:0]     quo_fix_s, rem_fix_s;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = dzo_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    assign is_div_s  = op[1];
    assign run_div_s = op_q[1];
    assign a_neg_s   = op[0] & src_a[XLEN-1];
    assign b_neg_s   = op[0] & src_b[XLEN-1];

    // Operand magnitudes: abs value for signed ops, raw value otherwise.
    always_comb begin
        mag_a_s = src_a;
        mag_b_s = src_b;
        if (a_neg_s) begin
            mag_a_s = ~src_a + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            mag_a_s = src_a;
        end
        if (b_neg_s) begin
            mag_b_s = ~src_b + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            mag_b_s = src_b;
        end
    end

    // Restoring divide: shift in the next dividend bit, trial-subtract the divisor.
    assign rem_sh_s = {acc_q[XLEN-1:0], q_q[XLEN-1]};
    assign diff_s   = rem_sh_s - {1'b0, sh_q[XLEN-1:0]};

    assign step_last_s = (cnt_q == CNT_W'(XLEN-1));

    mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .prod_i     (acc_q),
        .neg_prod_i (neg_a_q ^ neg_b_q),
        .quo_i      (q_q),
        .neg_quo_i  (neg_a_q ^ neg_b_q),
        .rem_i      (acc_q[XLEN-1:0]),
        .neg_rem_i  (neg_a_q),
        .prod_o     (prod_fix_s),
        .quo_o      (quo_fix_s),
        .rem_o      (rem_fix_s)
    );

    // Next-state and datapath control for the IDLE/RUN/FIX sequencer.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dzo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = mdu_op_e'(op);
                    neg_a_d = a_neg_s;
                    neg_b_d = b_neg_s;
                    cnt_d   = {CNT_W{1'b0}};
                    if (is_div_s && (src_b == {XLEN{1'b0}})) begin
                        // Raw dividend parked in acc so FIX can return it as HI.
                        dz_d    = 1'b1;
                        acc_d   = {{XLEN{1'b0}}, src_a};
                        state_d = FIX;
                    end else if (is_div_s) begin
                        dz_d    = 1'b0;
                        acc_d   = {(2*XLEN){1'b0}};
                        sh_d    = {{XLEN{1'b0}}, mag_b_s};
                        q_d     = mag_a_s;
                        state_d = RUN;
                    end else begin
                        dz_d    = 1'b0;
                        acc_d   = {(2*XLEN){1'b0}};
                        sh_d    = {{XLEN{1'b0}}, mag_a_s};
                        q_d     = mag_b_s;
                        state_d = RUN;
                    end
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (run_div_s) begin
                    if (!diff_s[XLEN]) begin
                        acc_d = {{XLEN{1'b0}}, diff_s[XLEN-1:0]};
                        q_d   = {q_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = {{XLEN{1'b0}}, rem_sh_s[XLEN-1:0]};
                        q_d   = {q_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    if (q_q[0]) begin
                        acc_d = acc_q + sh_q;
                    end else begin
                        acc_d = acc_q;
                    end
                    sh_d = {sh_q[2*XLEN-2:0], 1'b0};
                    q_d  = {1'b0, q_q[XLEN-1:1]};
                end
`ifdef MDU_EARLY_TERM_EN
                if (step_last_s || (!run_div_s && (q_q[XLEN-1:1] == {(XLEN-1){1'b0}}))) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
`else
                if (step_last_s) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
`endif
            end
            FIX: begin
                if (dz_q) begin
                    hi_d = acc_q[XLEN-1:0];
                    lo_d = XLEN'(DIV0_LO);
                end else if (run_div_s) begin
                    hi_d = rem_fix_s;
                    lo_d = quo_fix_s;
                end else begin
                    hi_d = prod_fix_s[2*XLEN-1:XLEN];
                    lo_d = prod_fix_s[XLEN-1:0];
                end
                done_d  = 1'b1;
                dzo_d   = dz_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and HI/LO registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MDU_MULTU;
            acc_q   <= {(2*XLEN){1'b0}};
            sh_q    <= {(2*XLEN){1'b0}};
            q_q     <= {XLEN{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= {XLEN{1'b0}};
            lo_q    <= {XLEN{1'b0}};
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

endmodule
